// File: rtl/pipeline_control_if.sv
// rtl/pipeline_control_if.sv - hazard inputs and stage control outputs of the pipeline sequencer
// Signal prefixes are from the controller's point of view: i_ toward it, o_ from it.
interface pipeline_control_if #(
   parameter int CNT_W = 16,
   parameter int MUL_W = 2
);
   logic             i_dec_valid;
   logic [3:0]       i_dec_rn;
   logic [3:0]       i_dec_rm;
   logic [3:0]       i_dec_rs;
   logic             i_dec_use_rn;
   logic             i_dec_use_rm;
   logic             i_dec_use_rs;
   logic             i_ex_is_load;
   logic             i_ex_wb_en;
   logic [3:0]       i_ex_rd;
   logic             i_ex_mul_start;
   logic [MUL_W-1:0] i_ex_mul_cycles;
   logic             i_branch_taken;
   logic             i_mem_busy;
   logic             i_perf_clr;

   logic             o_pc_en;
   logic             o_pc_load;
   logic             o_en_ifid;
   logic             o_en_idex;
   logic             o_en_exmem;
   logic             o_en_memwb;
   logic             o_bub_ifid;
   logic             o_bub_idex;
   logic             o_bub_exmem;
   logic [CNT_W-1:0] o_stall_cnt;
   logic [CNT_W-1:0] o_flush_cnt;

   modport master (
      output i_dec_valid, i_dec_rn, i_dec_rm, i_dec_rs,
             i_dec_use_rn, i_dec_use_rm, i_dec_use_rs,
             i_ex_is_load, i_ex_wb_en, i_ex_rd,
             i_ex_mul_start, i_ex_mul_cycles,
             i_branch_taken, i_mem_busy, i_perf_clr,
      input  o_pc_en, o_pc_load,
             o_en_ifid, o_en_idex, o_en_exmem, o_en_memwb,
             o_bub_ifid, o_bub_idex, o_bub_exmem,
             o_stall_cnt, o_flush_cnt
   );

   modport slave (
      input  i_dec_valid, i_dec_rn, i_dec_rm, i_dec_rs,
             i_dec_use_rn, i_dec_use_rm, i_dec_use_rs,
             i_ex_is_load, i_ex_wb_en, i_ex_rd,
             i_ex_mul_start, i_ex_mul_cycles,
             i_branch_taken, i_mem_busy, i_perf_clr,
      output o_pc_en, o_pc_load,
             o_en_ifid, o_en_idex, o_en_exmem, o_en_memwb,
             o_bub_ifid, o_bub_idex, o_bub_exmem,
             o_stall_cnt, o_flush_cnt
   );
endinterface

// File: rtl/pipeline_control.sv
// rtl/pipeline_control.sv - pipeline stage sequencer with hazard priority and perf counters
// Priority: mem wait > multi-cycle execute > taken branch > load-use > normal flow.
module pipeline_control #(
   parameter int CNT_W = 16,
   parameter int MUL_W = 2
) (
   input logic              i_clk,
   input logic              i_rst,
   pipeline_control_if.slave io
);
   typedef enum logic {
      ST_RUN = 1'b0,
      ST_MUL = 1'b1
   } state_t;

   localparam logic [MUL_W-1:0] MUL_ONE = {{(MUL_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t           r_state;
   state_t           w_state_nxt;
   logic [MUL_W-1:0] r_mul_cnt;
   logic [MUL_W-1:0] w_mul_cnt_nxt;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   logic w_load_use;
   logic w_mul_begin;
   logic w_mul_hold;
   logic w_stall_inc;
   logic w_flush_inc;

   logic w_pc_en;
   logic w_pc_load;
   logic w_en_ifid;
   logic w_en_idex;
   logic w_en_exmem;
   logic w_en_memwb;
   logic w_bub_ifid;
   logic w_bub_idex;
   logic w_bub_exmem;

   always_comb begin
      w_load_use = io.i_dec_valid & io.i_ex_is_load & io.i_ex_wb_en &
                   ((io.i_dec_use_rn & (io.i_dec_rn == io.i_ex_rd)) |
                    (io.i_dec_use_rm & (io.i_dec_rm == io.i_ex_rd)) |
                    (io.i_dec_use_rs & (io.i_dec_rs == io.i_ex_rd)));
   end

   // The MUL counter holds the extra cycles still owed after the current one.
   assign w_mul_begin = (r_state == ST_RUN) & io.i_ex_mul_start & (io.i_ex_mul_cycles != '0);
   assign w_mul_hold  = w_mul_begin | ((r_state == ST_MUL) & (r_mul_cnt != '0));

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= ST_RUN;
         r_mul_cnt <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_mul_cnt <= w_mul_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_mul_cnt_nxt = r_mul_cnt;
      w_stall_inc   = 1'b0;
      w_flush_inc   = 1'b0;
      w_pc_en       = 1'b1;
      w_pc_load     = 1'b0;
      w_en_ifid     = 1'b1;
      w_en_idex     = 1'b1;
      w_en_exmem    = 1'b1;
      w_en_memwb    = 1'b1;
      w_bub_ifid    = 1'b0;
      w_bub_idex    = 1'b0;
      w_bub_exmem   = 1'b0;

      if (i_rst) begin
         w_state_nxt   = ST_RUN;
         w_mul_cnt_nxt = '0;
         w_pc_en       = 1'b0;
         w_en_ifid     = 1'b0;
         w_en_idex     = 1'b0;
         w_en_exmem    = 1'b0;
         w_en_memwb    = 1'b0;
         w_bub_ifid    = 1'b1;
         w_bub_idex    = 1'b1;
         w_bub_exmem   = 1'b1;
      end else if (io.i_mem_busy) begin
         w_stall_inc   = 1'b1;
         w_pc_en       = 1'b0;
         w_en_ifid     = 1'b0;
         w_en_idex     = 1'b0;
         w_en_exmem    = 1'b0;
         w_en_memwb    = 1'b0;
      end else if (w_mul_hold) begin
         // EX keeps its instruction; MEM receives a bubble while WB drains.
         w_state_nxt   = ST_MUL;
         w_mul_cnt_nxt = w_mul_begin ? (io.i_ex_mul_cycles - MUL_ONE) : (r_mul_cnt - MUL_ONE);
         w_stall_inc   = 1'b1;
         w_pc_en       = 1'b0;
         w_en_ifid     = 1'b0;
         w_en_idex     = 1'b0;
         w_bub_exmem   = 1'b1;
      end else begin
         w_state_nxt = ST_RUN;
         if (io.i_branch_taken) begin
            w_flush_inc = 1'b1;
            w_pc_load   = 1'b1;
            w_bub_ifid  = 1'b1;
            w_bub_idex  = 1'b1;
         end else if (w_load_use) begin
            w_stall_inc = 1'b1;
            w_pc_en     = 1'b0;
            w_en_ifid   = 1'b0;
            w_bub_idex  = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst || io.i_perf_clr) begin
         r_stall_cnt <= '0;
      end else if (w_stall_inc && (r_stall_cnt != CNT_MAX)) begin
         r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst || io.i_perf_clr) begin
         r_flush_cnt <= '0;
      end else if (w_flush_inc && (r_flush_cnt != CNT_MAX)) begin
         r_flush_cnt <= r_flush_cnt + CNT_ONE;
      end
   end

   assign io.o_pc_en     = w_pc_en;
   assign io.o_pc_load   = w_pc_load;
   assign io.o_en_ifid   = w_en_ifid;
   assign io.o_en_idex   = w_en_idex;
   assign io.o_en_exmem  = w_en_exmem;
   assign io.o_en_memwb  = w_en_memwb;
   assign io.o_bub_ifid  = w_bub_ifid;
   assign io.o_bub_idex  = w_bub_idex;
   assign io.o_bub_exmem = w_bub_exmem;
   assign io.o_stall_cnt = r_stall_cnt;
   assign io.o_flush_cnt = r_flush_cnt;
endmodule

// File: tb/tb_pipeline_control.sv
// tb/tb_pipeline_control.sv - directed and random checks of pipeline_control against a cycle model
// Counter width is narrowed so saturation is reachable in a short run.
module tb_pipeline_control;
   localparam int CW   = 10;
   localparam int MW   = 2;
   localparam int CMAX = (1 << CW) - 1;

   logic clk;
   logic rst;

   pipeline_control_if #(.CNT_W(CW), .MUL_W(MW)) bus ();

   pipeline_control #(.CNT_W(CW), .MUL_W(MW)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .io    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec;
   int n_err;
   int m_rem;
   int m_stall;
   int m_flush;
   bit m_cnt_known;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      rst                 = 1'b0;
      bus.i_dec_valid     = 1'b0;
      bus.i_dec_rn        = 4'd0;
      bus.i_dec_rm        = 4'd0;
      bus.i_dec_rs        = 4'd0;
      bus.i_dec_use_rn    = 1'b0;
      bus.i_dec_use_rm    = 1'b0;
      bus.i_dec_use_rs    = 1'b0;
      bus.i_ex_is_load    = 1'b0;
      bus.i_ex_wb_en      = 1'b0;
      bus.i_ex_rd         = 4'd0;
      bus.i_ex_mul_start  = 1'b0;
      bus.i_ex_mul_cycles = '0;
      bus.i_branch_taken  = 1'b0;
      bus.i_mem_busy      = 1'b0;
      bus.i_perf_clr      = 1'b0;
   endtask

   // Expected controls as {pc_en,pc_load,en_ifid,en_idex,en_exmem,en_memwb,bub_ifid,bub_idex,bub_exmem}.
   // m_rem < 0: no multi-cycle op in EX; otherwise hold cycles still owed before its release cycle.
   task automatic model_eval(output logic [8:0] e, output bit s_inc, output bit f_inc, output int nrem);
      int  n;
      bit  lu;
      n  = int'(bus.i_ex_mul_cycles);
      lu = bus.i_dec_valid && bus.i_ex_is_load && bus.i_ex_wb_en &&
           ((bus.i_dec_use_rn && bus.i_dec_rn == bus.i_ex_rd) ||
            (bus.i_dec_use_rm && bus.i_dec_rm == bus.i_ex_rd) ||
            (bus.i_dec_use_rs && bus.i_dec_rs == bus.i_ex_rd));
      s_inc = 1'b0;
      f_inc = 1'b0;
      nrem  = m_rem;
      if (rst) begin
         e    = 9'b000000111;
         nrem = -1;
      end else if (bus.i_mem_busy) begin
         e     = 9'b000000000;
         s_inc = 1'b1;
      end else if ((m_rem < 0 && bus.i_ex_mul_start && n > 0) || m_rem > 0) begin
         e     = 9'b000011001;
         s_inc = 1'b1;
         nrem  = (m_rem < 0) ? n - 1 : m_rem - 1;
      end else begin
         nrem = -1;
         if (bus.i_branch_taken) begin
            e     = 9'b111111110;
            f_inc = 1'b1;
         end else if (lu) begin
            e     = 9'b000111010;
            s_inc = 1'b1;
         end else begin
            e = 9'b101111000;
         end
      end
   endtask

   task automatic cyc();
      logic [8:0] e;
      logic [8:0] o;
      bit         s_inc;
      bit         f_inc;
      int         nrem;
      @(negedge clk);
      model_eval(e, s_inc, f_inc, nrem);
      o = {bus.o_pc_en, bus.o_pc_load, bus.o_en_ifid, bus.o_en_idex, bus.o_en_exmem,
           bus.o_en_memwb, bus.o_bub_ifid, bus.o_bub_idex, bus.o_bub_exmem};
      chk("controls", 32'(o), 32'(e));
      if (m_cnt_known) begin
         chk("stall_cnt", 32'(bus.o_stall_cnt), 32'(m_stall));
         chk("flush_cnt", 32'(bus.o_flush_cnt), 32'(m_flush));
      end
      m_rem = nrem;
      if (rst || bus.i_perf_clr) begin
         m_stall = 0;
         m_flush = 0;
      end else begin
         if (s_inc && m_stall < CMAX) m_stall++;
         if (f_inc && m_flush < CMAX) m_flush++;
      end
      if (rst) m_cnt_known = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic clr_cycle();
      idle_inputs();
      bus.i_perf_clr = 1'b1;
      cyc();
      bus.i_perf_clr = 1'b0;
   endtask

   task automatic set_load_use(input bit use_rm);
      bus.i_dec_valid  = 1'b1;
      bus.i_ex_is_load = 1'b1;
      bus.i_ex_wb_en   = 1'b1;
      bus.i_ex_rd      = 4'd3;
      bus.i_dec_rm     = 4'd3;
      bus.i_dec_rn     = 4'd5;
      bus.i_dec_rs     = 4'd6;
      bus.i_dec_use_rm = use_rm;
   endtask

   initial begin
      n_vec       = 0;
      n_err       = 0;
      m_rem       = -1;
      m_stall     = 0;
      m_flush     = 0;
      m_cnt_known = 1'b0;
      idle_inputs();
      rst = 1'b1;
      #1;

      // reset for two cycles, then quiet pipeline
      cyc();
      cyc();
      rst = 1'b0;
      repeat (3) cyc();
      chk("idle_stall_zero", 32'(bus.o_stall_cnt), 32'd0);
      chk("idle_flush_zero", 32'(bus.o_flush_cnt), 32'd0);

      // load-use through rm, then the same fields with rm unused
      set_load_use(1'b1);
      cyc();
      idle_inputs();
      cyc();
      chk("lu_stall_one", 32'(bus.o_stall_cnt), 32'd1);
      set_load_use(1'b0);
      cyc();
      idle_inputs();
      cyc();
      chk("lu_unused_no_stall", 32'(bus.o_stall_cnt), 32'd1);

      // N=3 multiply: three holds then release; N=0 adds nothing
      clr_cycle();
      bus.i_ex_mul_start  = 1'b1;
      bus.i_ex_mul_cycles = 2'd3;
      repeat (4) cyc();
      idle_inputs();
      cyc();
      chk("mul3_stall", 32'(bus.o_stall_cnt), 32'd3);
      bus.i_ex_mul_start  = 1'b1;
      bus.i_ex_mul_cycles = 2'd0;
      cyc();
      idle_inputs();
      cyc();
      chk("mul0_no_stall", 32'(bus.o_stall_cnt), 32'd3);

      // branch wins over a simultaneous load-use
      set_load_use(1'b1);
      bus.i_branch_taken = 1'b1;
      cyc();
      idle_inputs();
      cyc();
      chk("br_flush", 32'(bus.o_flush_cnt), 32'd1);
      chk("br_stall_unchanged", 32'(bus.o_stall_cnt), 32'd3);

      // memory wait in the middle of an N=2 multiply
      clr_cycle();
      bus.i_ex_mul_start  = 1'b1;
      bus.i_ex_mul_cycles = 2'd2;
      cyc();
      bus.i_mem_busy = 1'b1;
      repeat (2) cyc();
      bus.i_mem_busy = 1'b0;
      cyc();
      chk("mem_mul_not_released", 32'(bus.o_pc_en), 32'd1);
      cyc();
      idle_inputs();
      cyc();
      chk("mem_mul_stall", 32'(bus.o_stall_cnt), 32'd4);

      // saturation, then clear racing a stall
      idle_inputs();
      bus.i_mem_busy = 1'b1;
      repeat (CMAX + 8) cyc();
      chk("stall_saturated", 32'(bus.o_stall_cnt), 32'(CMAX));
      bus.i_perf_clr = 1'b1;
      cyc();
      chk("clr_beats_inc", 32'(bus.o_stall_cnt), 32'd0);
      idle_inputs();

      // reset while a multiply is in progress
      bus.i_ex_mul_start  = 1'b1;
      bus.i_ex_mul_cycles = 2'd3;
      cyc();
      rst = 1'b1;
      cyc();
      idle_inputs();
      cyc();
      chk("rst_leaves_mul", 32'(bus.o_pc_en), 32'd1);

      // random traffic
      for (int i = 0; i < 1500; i++) begin
         rst                 = ($urandom_range(0, 63) == 0);
         bus.i_perf_clr      = ($urandom_range(0, 31) == 0);
         bus.i_mem_busy      = ($urandom_range(0, 5) == 0);
         bus.i_branch_taken  = ($urandom_range(0, 7) == 0);
         bus.i_ex_mul_start  = ($urandom_range(0, 5) == 0);
         bus.i_ex_mul_cycles = MW'($urandom_range(0, 3));
         bus.i_dec_valid     = ($urandom_range(0, 3) != 0);
         bus.i_ex_is_load    = ($urandom_range(0, 1) == 0);
         bus.i_ex_wb_en      = ($urandom_range(0, 3) != 0);
         bus.i_ex_rd         = 4'($urandom_range(0, 3));
         bus.i_dec_rn        = 4'($urandom_range(0, 3));
         bus.i_dec_rm        = 4'($urandom_range(0, 3));
         bus.i_dec_rs        = 4'($urandom_range(0, 3));
         bus.i_dec_use_rn    = ($urandom_range(0, 1) == 0);
         bus.i_dec_use_rm    = ($urandom_range(0, 1) == 0);
         bus.i_dec_use_rs    = ($urandom_range(0, 1) == 0);
         cyc();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/pipeline_control.md
Name: pipeline_control

Overview:
- Sequencer for the CPU pipeline register stages IF/ID, ID/EX, EX/MEM and MEM/WB.
- Drives a per-stage load enable and a per-stage bubble (clear-to-NOP) control, plus PC enable and load.
- Resolves four hazard sources in fixed priority: memory wait, multi-cycle execute, taken branch, load-use.
- Keeps two saturating performance counters: stall cycles and flushes.

Parameters:
- CNT_W, 16, width of the performance counters.
- MUL_W, 2, width of the extra-cycle count for multi-cycle execute operations.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- dec_valid  input  1  ID stage holds a valid instruction.
- dec_rn / dec_rm / dec_rs  input  4 each  ID source register numbers.
- dec_use_rn / dec_use_rm / dec_use_rs  input  1 each  the matching source field is actually read.
- ex_is_load  input  1  EX instruction is a load.
- ex_wb_en  input  1  EX instruction writes a register.
- ex_rd  input  4  EX destination register.
- ex_mul_start  input  1  EX instruction needs extra cycles.
- ex_mul_cycles  input  MUL_W  number of extra EX cycles (N).
- branch_taken  input  1  EX resolved a taken branch.
- mem_busy  input  1  data memory not ready; freezes the pipeline.
- perf_clr  input  1  clears both counters.
- pc_en  output  1  PC advances.
- pc_load  output  1  PC loads the branch target.
- en_ifid / en_idex / en_exmem / en_memwb  output  1 each  stage buffer load enables.
- bub_ifid / bub_idex / bub_exmem  output  1 each  the loaded value is a NOP bubble.
- stall_cnt  output  CNT_W  cycles with pc_en=0, excluding reset.
- flush_cnt  output  CNT_W  number of taken-branch flushes.

Behaviour:
- Enable and bubble outputs are combinational from state and inputs. The FSM state, mul counter and perf counters are registered.
- Reset (rst=1):
  - All enables, pc_en and pc_load = 0; all bub_* = 1.
  - Next state is RUN, mul counter = 0, stall_cnt = flush_cnt = 0.
  - Reset mid-multiply abandons the MUL state.
- FSM states: RUN, MUL.
- Priority 1, mem_busy=1 (any state):
  - All en_*, pc_en and pc_load = 0; bub_* = 0.
  - State and mul counter hold; stall_cnt increments.
- Priority 2, multi-cycle execute:
  - In RUN with ex_mul_start=1 and N>0: hold cycle, then go to MUL with counter = N-1.
  - In MUL with counter>0: hold cycle, counter decrements.
  - In MUL with counter=0: release cycle; evaluate priorities 3-4 and normal flow, next state RUN.
  - A hold cycle sets pc_en=en_ifid=en_idex=0 and en_exmem=bub_exmem=1 (bubble to MEM), en_memwb=1.
  - EX occupancy is N+1 cycles.
  - ex_mul_start is ignored in MUL, and N=0 causes no stall.
  - branch_taken is ignored during hold cycles.
- Priority 3, branch_taken=1 (RUN, or MUL release):
  - pc_en=pc_load=1, all en_*=1, bub_ifid=bub_idex=1.
  - flush_cnt increments.
  - Any simultaneous load-use hazard is discarded.
- Priority 4, load-use:
  - Hazard when dec_valid & ex_is_load & ex_wb_en and any used source equals ex_rd.
  - Response: pc_en=en_ifid=0, en_idex=bub_idex=1, en_exmem=en_memwb=1, exactly 1 cycle.
  - stall_cnt increments.
- Normal flow: pc_en and all en_* = 1, bub_* = 0, pc_load = 0.
- Counters:
  - Saturate at all-ones.
  - perf_clr zeroes them next cycle and overrides a same-cycle increment; rst overrides perf_clr.

Test Plan:
- Reset for 2 cycles, then idle with no hazards → during reset en_*=0 and bub_*=1; afterwards all en_*=1, pc_en=1, counters 0.
- Load to r3 in EX while ID reads r3 via rm with dec_use_rm=1 → one cycle of pc_en=0, bub_idex=1, stall_cnt=1. Same case with dec_use_rm=0 → no stall.
- ex_mul_start with N=3 → 3 hold cycles (bub_exmem=1, pc_en=0), release on the 4th, stall_cnt=3. N=0 → no hold.
- branch_taken together with a load-use match → pc_load=1, bub_ifid=bub_idex=1, flush_cnt=1, stall_cnt unchanged.
- mem_busy high for 2 cycles in the middle of a MUL with N=2 → everything frozen and counter held; the release cycle comes 2 cycles late; stall_cnt=4.
- Preload stall_cnt near 0xFFFF, keep stalling → holds at 0xFFFF. perf_clr together with a stall → counter reads 0 next cycle. rst asserted in MUL → RUN next cycle.
